// File: rtl/d_cache_nway_plru.sv
// N-way set-associative write-back data cache with tree pseudo-LRU replacement,
// one-word lines, store merging, and an uncached pass-through for kseg1.
module d_cache_nway_plru #(
    parameter int WAYS        = 4,
    parameter int INDEX_WIDTH = 7
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        cpu_data_req,
    input  logic        cpu_data_wr,
    input  logic [1:0]  cpu_data_size,
    input  logic [31:0] cpu_data_addr,
    input  logic [31:0] cpu_data_wdata,
    output logic [31:0] cpu_data_rdata,
    output logic        cpu_data_addr_ok,
    output logic        cpu_data_data_ok,
    output logic        cache_data_req,
    output logic        cache_data_wr,
    output logic [1:0]  cache_data_size,
    output logic [31:0] cache_data_addr,
    output logic [31:0] cache_data_wdata,
    input  logic [31:0] cache_data_rdata,
    input  logic        cache_data_addr_ok,
    input  logic        cache_data_data_ok
);
    localparam int SETS      = 1 << INDEX_WIDTH;
    localparam int TAG_WIDTH = 30 - INDEX_WIDTH;
    localparam int WAY_BITS  = $clog2(WAYS);

    typedef enum logic [1:0] {IDLE, WB, RF, UNC} state_t;
    state_t state;

    // plru bit n holds tree node n (root = 1); bit 0 is never used
    logic [WAYS-1:0]      valid [SETS];
    logic [WAYS-1:0]      dirty [SETS];
    logic [WAYS-1:0]      plru  [SETS];
    logic [TAG_WIDTH-1:0] tags  [SETS][WAYS];
    logic [31:0]          data  [SETS][WAYS];

    logic [29:0]         lat_line;
    logic                lat_wr;
    logic [3:0]          lat_be;
    logic [31:0]         lat_wdata;
    logic [WAY_BITS-1:0] lat_way;

    logic [INDEX_WIDTH-1:0] req_idx, upd_idx;
    logic [TAG_WIDTH-1:0]   req_tag, upd_tag;
    logic [3:0]             req_be;
    logic                   req_uncached, accept, hit, full_store, victim_dirty, lat_full;
    logic [WAY_BITS-1:0]    hit_way, victim, upd_way;
    logic                   upd_en, upd_write, upd_dirty;
    logic [31:0]            upd_data;

    function automatic logic [31:0] merge(input logic [31:0] old_word,
                                          input logic [31:0] new_word,
                                          input logic [3:0]  be);
        logic [31:0] w;
        w = old_word;
        for (int i = 0; i < 4; i++)
            if (be[i]) w[8*i +: 8] = new_word[8*i +: 8];
        return w;
    endfunction

    function automatic logic [WAY_BITS-1:0] tree_victim(input logic [WAYS-1:0] bits);
        logic [WAY_BITS-1:0] node, way;
        logic                b;
        node = WAY_BITS'(1);
        way  = '0;
        for (int l = 0; l < WAY_BITS; l++) begin
            b    = bits[node];
            way  = (way << 1) | WAY_BITS'(b);
            node = (node << 1) | WAY_BITS'(b);
        end
        return way;
    endfunction

    function automatic logic [WAYS-1:0] plru_touch(input logic [WAYS-1:0] bits,
                                                   input logic [WAY_BITS-1:0] way);
        logic [WAYS-1:0]     nb;
        logic [WAY_BITS-1:0] node, w;
        logic                dir;
        nb   = bits;
        node = WAY_BITS'(1);
        w    = way;
        for (int l = 0; l < WAY_BITS; l++) begin
            dir      = w[WAY_BITS-1];
            nb[node] = ~dir;
            node     = (node << 1) | WAY_BITS'(dir);
            w        = w << 1;
        end
        return nb;
    endfunction

    assign req_idx      = cpu_data_addr[INDEX_WIDTH+1:2];
    assign req_tag      = cpu_data_addr[31:INDEX_WIDTH+2];
    assign req_uncached = (cpu_data_addr[31:29] == 3'b101);
    assign accept       = resetn && (state == IDLE) && cpu_data_req;
    assign full_store   = cpu_data_wr && (req_be == 4'b1111);
    assign lat_full     = lat_wr && (lat_be == 4'b1111);
    assign victim_dirty = valid[req_idx][victim] && dirty[req_idx][victim];
    assign cpu_data_addr_ok = accept;

    always_comb begin
        case (cpu_data_size)
            2'd0:    req_be = 4'b0001 << cpu_data_addr[1:0];
            2'd1:    req_be = 4'b0011 << cpu_data_addr[1:0];
            default: req_be = 4'b1111;
        endcase
        hit     = 1'b0;
        hit_way = '0;
        for (int w = 0; w < WAYS; w++)
            if (valid[req_idx][w] && tags[req_idx][w] == req_tag) begin
                hit     = 1'b1;
                hit_way = WAY_BITS'(w);
            end
        victim = tree_victim(plru[req_idx]);
        for (int w = WAYS - 1; w >= 0; w--)
            if (!valid[req_idx][w]) victim = WAY_BITS'(w);
    end

    // Decide what the array and PLRU write on the coming edge, and what the CPU sees now
    always_comb begin
        upd_en           = 1'b0;
        upd_write        = 1'b0;
        upd_idx          = req_idx;
        upd_way          = hit_way;
        upd_tag          = req_tag;
        upd_data         = '0;
        upd_dirty        = 1'b0;
        cpu_data_data_ok = 1'b0;
        cpu_data_rdata   = data[req_idx][hit_way];
        case (state)
            IDLE: if (accept && !req_uncached) begin
                if (hit) begin
                    upd_en           = 1'b1;
                    cpu_data_data_ok = 1'b1;
                    if (cpu_data_wr) begin
                        upd_write = 1'b1;
                        upd_dirty = 1'b1;
                        upd_data  = merge(data[req_idx][hit_way], cpu_data_wdata, req_be);
                    end
                end else if (full_store && !victim_dirty) begin
                    upd_en           = 1'b1;
                    upd_write        = 1'b1;
                    upd_way          = victim;
                    upd_dirty        = 1'b1;
                    upd_data         = cpu_data_wdata;
                    cpu_data_data_ok = 1'b1;
                end
            end
            WB: if (cache_data_data_ok && lat_full) begin
                upd_en           = 1'b1;
                upd_write        = 1'b1;
                upd_idx          = lat_line[INDEX_WIDTH-1:0];
                upd_way          = lat_way;
                upd_tag          = lat_line[29:INDEX_WIDTH];
                upd_dirty        = 1'b1;
                upd_data         = lat_wdata;
                cpu_data_data_ok = 1'b1;
            end
            RF: if (cache_data_data_ok) begin
                upd_en           = 1'b1;
                upd_write        = 1'b1;
                upd_idx          = lat_line[INDEX_WIDTH-1:0];
                upd_way          = lat_way;
                upd_tag          = lat_line[29:INDEX_WIDTH];
                upd_dirty        = lat_wr;
                upd_data         = lat_wr ? merge(cache_data_rdata, lat_wdata, lat_be)
                                          : cache_data_rdata;
                cpu_data_data_ok = 1'b1;
                cpu_data_rdata   = cache_data_rdata;
            end
            UNC: begin
                cpu_data_data_ok = cache_data_data_ok;
                cpu_data_rdata   = cache_data_rdata;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int s = 0; s < SETS; s++) begin
                valid[s] <= '0;
                dirty[s] <= '0;
                plru[s]  <= '0;
            end
        end else if (upd_en) begin
            plru[upd_idx] <= plru_touch(plru[upd_idx], upd_way);
            if (upd_write) begin
                valid[upd_idx][upd_way] <= 1'b1;
                dirty[upd_idx][upd_way] <= upd_dirty;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (upd_en && upd_write) begin
            tags[upd_idx][upd_way] <= upd_tag;
            data[upd_idx][upd_way] <= upd_data;
        end
    end

    // cache_data_req doubles as the per-transaction issue flag: it drops on addr_ok
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state            <= IDLE;
            cache_data_req   <= 1'b0;
            cache_data_wr    <= 1'b0;
            cache_data_size  <= 2'd0;
            cache_data_addr  <= '0;
            cache_data_wdata <= '0;
            lat_line         <= '0;
            lat_wr           <= 1'b0;
            lat_be           <= '0;
            lat_wdata        <= '0;
            lat_way          <= '0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    lat_line  <= cpu_data_addr[31:2];
                    lat_wr    <= cpu_data_wr;
                    lat_be    <= req_be;
                    lat_wdata <= cpu_data_wdata;
                    lat_way   <= victim;
                    if (req_uncached) begin
                        state            <= UNC;
                        cache_data_req   <= 1'b1;
                        cache_data_wr    <= cpu_data_wr;
                        cache_data_size  <= cpu_data_size;
                        cache_data_addr  <= cpu_data_addr;
                        cache_data_wdata <= cpu_data_wdata;
                    end else if (!hit) begin
                        if (victim_dirty) begin
                            state            <= WB;
                            cache_data_req   <= 1'b1;
                            cache_data_wr    <= 1'b1;
                            cache_data_size  <= 2'd2;
                            cache_data_addr  <= {tags[req_idx][victim], req_idx, 2'b00};
                            cache_data_wdata <= data[req_idx][victim];
                        end else if (!full_store) begin
                            state           <= RF;
                            cache_data_req  <= 1'b1;
                            cache_data_wr   <= 1'b0;
                            cache_data_size <= 2'd2;
                            cache_data_addr <= {cpu_data_addr[31:2], 2'b00};
                        end
                    end
                end
                WB: begin
                    if (cache_data_req && cache_data_addr_ok) cache_data_req <= 1'b0;
                    if (cache_data_data_ok) begin
                        cache_data_wr <= 1'b0;
                        if (lat_full) begin
                            state <= IDLE;
                        end else begin
                            state           <= RF;
                            cache_data_req  <= 1'b1;
                            cache_data_size <= 2'd2;
                            cache_data_addr <= {lat_line, 2'b00};
                        end
                    end
                end
                default: begin
                    if (cache_data_req && cache_data_addr_ok) cache_data_req <= 1'b0;
                    if (cache_data_data_ok) begin
                        state         <= IDLE;
                        cache_data_wr <= 1'b0;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_d_cache_nway_plru.sv
// Scoreboard bench for d_cache_nway_plru: a small word memory answers the
// memory port while CPU results and memory requests are checked against queues.
module tb_d_cache_nway_plru;
    logic        clk = 1'b0;
    logic        resetn;
    logic        cpu_data_req, cpu_data_wr;
    logic [1:0]  cpu_data_size;
    logic [31:0] cpu_data_addr, cpu_data_wdata, cpu_data_rdata;
    logic        cpu_data_addr_ok, cpu_data_data_ok;
    logic        cache_data_req, cache_data_wr;
    logic [1:0]  cache_data_size;
    logic [31:0] cache_data_addr, cache_data_wdata, cache_data_rdata;
    logic        cache_data_addr_ok, cache_data_data_ok;

    d_cache_nway_plru #(.WAYS(4), .INDEX_WIDTH(7)) dut (
        .clk(clk), .resetn(resetn),
        .cpu_data_req(cpu_data_req), .cpu_data_wr(cpu_data_wr),
        .cpu_data_size(cpu_data_size), .cpu_data_addr(cpu_data_addr),
        .cpu_data_wdata(cpu_data_wdata), .cpu_data_rdata(cpu_data_rdata),
        .cpu_data_addr_ok(cpu_data_addr_ok), .cpu_data_data_ok(cpu_data_data_ok),
        .cache_data_req(cache_data_req), .cache_data_wr(cache_data_wr),
        .cache_data_size(cache_data_size), .cache_data_addr(cache_data_addr),
        .cache_data_wdata(cache_data_wdata), .cache_data_rdata(cache_data_rdata),
        .cache_data_addr_ok(cache_data_addr_ok), .cache_data_data_ok(cache_data_data_ok)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic        wr;
        logic [1:0]  size;
        logic [31:0] wdata;
    } mem_txn_t;

    typedef struct {
        logic [31:0] rdata;
        bit          is_load;
        bit          same_cycle;
    } cpu_exp_t;

    mem_txn_t    mem_q[$];
    cpu_exp_t    cpu_q[$];
    logic [31:0] mem [logic [31:0]];
    int          checks = 0;
    int          failures = 0;
    bit          hold_mem = 1'b0;
    bit          mem_slow = 1'b0;

    function automatic logic [31:0] memDefault(input logic [31:0] a);
        return 32'hC0DE_0000 | {16'h0000, a[15:0]};
    endfunction

    function automatic logic [31:0] memRead(input logic [31:0] a);
        logic [31:0] wa;
        wa = {a[31:2], 2'b00};
        if (mem.exists(wa)) return mem[wa];
        return memDefault(wa);
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%h expected=%h", tag, actual, expected);
        end
    endtask

    task automatic expectMem(input logic [31:0] addr, input logic wr, input logic [1:0] size,
                             input logic [31:0] wdata);
        mem_txn_t t;
        t.addr = addr; t.wr = wr; t.size = size; t.wdata = wdata;
        mem_q.push_back(t);
    endtask

    // Memory model: accepts at a falling edge, answers the same cycle or one cycle later
    initial begin : mem_responder
        logic        pending;
        logic [31:0] pend_data;
        mem_txn_t    e;
        pending = 1'b0;
        pend_data = '0;
        cache_data_addr_ok = 1'b0;
        cache_data_data_ok = 1'b0;
        cache_data_rdata = '0;
        forever begin
            @(negedge clk);
            cache_data_addr_ok = 1'b0;
            cache_data_data_ok = 1'b0;
            if (!resetn) begin
                pending = 1'b0;
            end else if (pending) begin
                cache_data_data_ok = 1'b1;
                cache_data_rdata = pend_data;
                pending = 1'b0;
            end else if (cache_data_req && !hold_mem) begin
                if (mem_q.size() == 0) begin
                    checkOutput("mem_unexpected_req", 32'(mem_q.size()), 32'd1);
                end else begin
                    e = mem_q.pop_front();
                    checkOutput($sformatf("mem_addr@%h", e.addr), cache_data_addr, e.addr);
                    checkOutput($sformatf("mem_wr@%h", e.addr), 32'(cache_data_wr), 32'(e.wr));
                    checkOutput($sformatf("mem_size@%h", e.addr), 32'(cache_data_size), 32'(e.size));
                    if (e.wr) checkOutput($sformatf("mem_wdata@%h", e.addr), cache_data_wdata, e.wdata);
                end
                if (cache_data_wr) mem[{cache_data_addr[31:2], 2'b00}] = cache_data_wdata;
                pend_data = cache_data_wr ? 32'h0 : memRead(cache_data_addr);
                cache_data_addr_ok = 1'b1;
                if (mem_slow) begin
                    pending = 1'b1;
                end else begin
                    cache_data_data_ok = 1'b1;
                    cache_data_rdata = pend_data;
                end
            end
        end
    end

    task automatic applyStimulus(input logic wr, input logic [1:0] size, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [31:0] exp_rdata,
                                 input bit exp_same);
        cpu_exp_t    exp_e, got;
        bit          done, same;
        logic [31:0] rd;
        exp_e.rdata = exp_rdata;
        exp_e.is_load = !wr;
        exp_e.same_cycle = exp_same;
        cpu_q.push_back(exp_e);
        done = 1'b0;
        same = 1'b0;
        rd = '0;
        @(negedge clk);
        cpu_data_req = 1'b1;
        cpu_data_wr = wr;
        cpu_data_size = size;
        cpu_data_addr = addr;
        cpu_data_wdata = wdata;
        #1;
        checkOutput($sformatf("addr_ok@%h", addr), 32'(cpu_data_addr_ok), 32'd1);
        if (cpu_data_data_ok) begin
            done = 1'b1;
            same = 1'b1;
            rd = cpu_data_rdata;
        end
        @(posedge clk);
        #1;
        cpu_data_req = 1'b0;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            #1;
            if (cpu_data_data_ok) begin
                done = 1'b1;
                rd = cpu_data_rdata;
            end
        end
        got = cpu_q.pop_front();
        checkOutput($sformatf("data_ok_seen@%h", addr), 32'(done), 32'd1);
        if (done) begin
            checkOutput($sformatf("same_cycle@%h", addr), 32'(same), 32'(got.same_cycle));
            if (got.is_load) checkOutput($sformatf("rdata@%h", addr), rd, got.rdata);
        end
    endtask

    initial begin : watchdog
        #400000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : main
        bit seen;
        resetn = 1'b0;
        cpu_data_req = 1'b1;
        cpu_data_wr = 1'b0;
        cpu_data_size = 2'd2;
        cpu_data_addr = 32'h0000_0040;
        cpu_data_wdata = '0;
        mem[32'h0000_0040] = 32'h1234_5678;
        repeat (2) @(negedge clk);
        #1;
        checkOutput("reset_addr_ok", 32'(cpu_data_addr_ok), 32'd0);
        checkOutput("reset_data_ok", 32'(cpu_data_data_ok), 32'd0);
        checkOutput("reset_mem_req", 32'(cache_data_req), 32'd0);
        checkOutput("reset_mem_wr", 32'(cache_data_wr), 32'd0);
        cpu_data_req = 1'b0;
        @(negedge clk);
        resetn = 1'b1;

        // Miss then hit, then a byte store merged into the cached word
        expectMem(32'h0000_0040, 1'b0, 2'd2, 32'h0);
        applyStimulus(1'b0, 2'd2, 32'h0000_0040, 32'h0, 32'h1234_5678, 1'b0);
        applyStimulus(1'b0, 2'd2, 32'h0000_0040, 32'h0, 32'h1234_5678, 1'b1);
        applyStimulus(1'b1, 2'd0, 32'h0000_0041, 32'h0000_AB00, 32'h0, 1'b1);
        applyStimulus(1'b0, 2'd2, 32'h0000_0040, 32'h0, 32'h1234_AB78, 1'b1);

        // Set 0: fill ways 0..3 with way 2 dirtied, touch way 0, fifth tag evicts way 2
        mem_slow = 1'b1;
        expectMem(32'h0000_0000, 1'b0, 2'd2, 32'h0);
        applyStimulus(1'b0, 2'd2, 32'h0000_0000, 32'h0, memDefault(32'h0000_0000), 1'b0);
        expectMem(32'h0000_0200, 1'b0, 2'd2, 32'h0);
        applyStimulus(1'b0, 2'd2, 32'h0000_0200, 32'h0, memDefault(32'h0000_0200), 1'b0);
        expectMem(32'h0000_0400, 1'b0, 2'd2, 32'h0);
        applyStimulus(1'b0, 2'd2, 32'h0000_0400, 32'h0, memDefault(32'h0000_0400), 1'b0);
        applyStimulus(1'b1, 2'd2, 32'h0000_0400, 32'hDEAD_BEEF, 32'h0, 1'b1);
        expectMem(32'h0000_0600, 1'b0, 2'd2, 32'h0);
        applyStimulus(1'b0, 2'd2, 32'h0000_0600, 32'h0, memDefault(32'h0000_0600), 1'b0);
        applyStimulus(1'b0, 2'd2, 32'h0000_0000, 32'h0, memDefault(32'h0000_0000), 1'b1);
        expectMem(32'h0000_0400, 1'b1, 2'd2, 32'hDEAD_BEEF);
        expectMem(32'h0000_0800, 1'b0, 2'd2, 32'h0);
        applyStimulus(1'b0, 2'd2, 32'h0000_0800, 32'h0, memDefault(32'h0000_0800), 1'b0);
        applyStimulus(1'b0, 2'd2, 32'h0000_0000, 32'h0, memDefault(32'h0000_0000), 1'b1);
        applyStimulus(1'b0, 2'd2, 32'h0000_0600, 32'h0, memDefault(32'h0000_0600), 1'b1);
        expectMem(32'h0000_0400, 1'b0, 2'd2, 32'h0);
        applyStimulus(1'b0, 2'd2, 32'h0000_0400, 32'h0, 32'hDEAD_BEEF, 1'b0);

        // Set 1: full-word store miss installs without memory, later written back
        mem_slow = 1'b0;
        applyStimulus(1'b1, 2'd2, 32'h0000_0004, 32'h1122_3344, 32'h0, 1'b1);
        applyStimulus(1'b0, 2'd2, 32'h0000_0004, 32'h0, 32'h1122_3344, 1'b1);
        for (int i = 1; i < 4; i++) begin
            expectMem(32'h0000_0004 + 32'(i * 32'h200), 1'b0, 2'd2, 32'h0);
            applyStimulus(1'b0, 2'd2, 32'h0000_0004 + 32'(i * 32'h200), 32'h0,
                          memDefault(32'h0000_0004 + 32'(i * 32'h200)), 1'b0);
        end
        expectMem(32'h0000_0004, 1'b1, 2'd2, 32'h1122_3344);
        expectMem(32'h0000_0804, 1'b0, 2'd2, 32'h0);
        applyStimulus(1'b0, 2'd2, 32'h0000_0804, 32'h0, memDefault(32'h0000_0804), 1'b0);

        // Set 2: halfword store miss refills then merges
        expectMem(32'h0000_0008, 1'b0, 2'd2, 32'h0);
        applyStimulus(1'b1, 2'd1, 32'h0000_000A, 32'hBEEF_0000, 32'h0, 1'b0);
        applyStimulus(1'b0, 2'd2, 32'h0000_0008, 32'h0, 32'hBEEF_0008, 1'b1);

        // Uncached kseg1: every access goes to memory with its own size and address
        expectMem(32'hBFC0_0000, 1'b0, 2'd2, 32'h0);
        applyStimulus(1'b0, 2'd2, 32'hBFC0_0000, 32'h0, memDefault(32'hBFC0_0000), 1'b0);
        expectMem(32'hBFC0_0000, 1'b0, 2'd2, 32'h0);
        applyStimulus(1'b0, 2'd2, 32'hBFC0_0000, 32'h0, memDefault(32'hBFC0_0000), 1'b0);
        expectMem(32'hBFC0_0003, 1'b0, 2'd0, 32'h0);
        applyStimulus(1'b0, 2'd0, 32'hBFC0_0003, 32'h0, memDefault(32'hBFC0_0000), 1'b0);

        // Set 4: four dirty full-word installs, then reset lands in the writeback
        for (int i = 0; i < 4; i++)
            applyStimulus(1'b1, 2'd2, 32'h0000_0010 + 32'(i * 32'h200),
                          32'hA0A0_0010 + 32'(i * 32'h200), 32'h0, 1'b1);
        hold_mem = 1'b1;
        @(negedge clk);
        cpu_data_req = 1'b1;
        cpu_data_wr = 1'b0;
        cpu_data_size = 2'd2;
        cpu_data_addr = 32'h0000_0810;
        @(posedge clk);
        #1;
        cpu_data_req = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            #1;
            seen = cache_data_req;
        end
        checkOutput("wb_req_seen", 32'(seen), 32'd1);
        checkOutput("wb_addr", cache_data_addr, 32'h0000_0010);
        checkOutput("wb_wr", 32'(cache_data_wr), 32'd1);
        checkOutput("wb_wdata", cache_data_wdata, 32'hA0A0_0010);
        #2;
        resetn = 1'b0;
        #1;
        checkOutput("abort_mem_req", 32'(cache_data_req), 32'd0);
        checkOutput("abort_mem_wr", 32'(cache_data_wr), 32'd0);
        checkOutput("abort_data_ok", 32'(cpu_data_data_ok), 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        hold_mem = 1'b0;
        expectMem(32'h0000_0040, 1'b0, 2'd2, 32'h0);
        applyStimulus(1'b0, 2'd2, 32'h0000_0040, 32'h0, 32'h1234_5678, 1'b0);

        repeat (2) @(negedge clk);
        checkOutput("mem_q_drained", 32'(mem_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
